// File: rtl/counter_xn_if.sv
// Register write/read path between the CPU-side master and the counter block.
interface counter_xn_if #(
  parameter int unsigned ADDR_W = 6
);
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [31:0]       rdata;

  modport master (output we, addr, wdata, input rdata);
  modport slave  (input we, addr, wdata, output rdata);
endinterface

// File: rtl/counter_xn.sv
// N_CH independent tick-driven counter channels (one-shot, periodic, PWM, free-run)
// with sticky expiry flags, a combined maskable interrupt and a word-addressed register map.
module counter_xn #(
  parameter int unsigned N_CH   = 3,
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned ADDR_W = 6
) (
  input  logic            clk,
  input  logic            RSTN,
  counter_xn_if.slave     bus,
  input  logic [N_CH-1:0] tick_in,
  output logic [N_CH-1:0] cnt_out,
  output logic            irq
);

  localparam int unsigned CH_W = ADDR_W - 3;
  localparam int unsigned WP1  = WIDTH + 1;

  typedef enum logic [1:0] {
    M_ONESHOT  = 2'd0,
    M_PERIODIC = 2'd1,
    M_PWM      = 2'd2,
    M_FREE     = 2'd3
  } mode_e;

  logic [N_CH-1:0]  en_q, en_d;
  logic [N_CH-1:0]  irq_en_q, irq_en_d;
  logic [N_CH-1:0]  expired_q, expired_d;
  logic [N_CH-1:0]  tick_q;
  logic [N_CH-1:0]  cnt_out_d;
  logic [N_CH-1:0]  exp_set;
  logic [N_CH-1:0]  ev;
  logic [N_CH-1:0]  wr_ctrl, wr_load, wr_cmp, wr_status;
  mode_e            mode_q [N_CH];
  mode_e            mode_d [N_CH];
  logic [WIDTH-1:0] load_q [N_CH];
  logic [WIDTH-1:0] load_d [N_CH];
  logic [WIDTH-1:0] cmp_q [N_CH];
  logic [WIDTH-1:0] cmp_d [N_CH];
  logic [WIDTH-1:0] count_q [N_CH];
  logic [WIDTH-1:0] count_d [N_CH];

  logic [CH_W-1:0]  ch_sel;
  logic [2:0]       reg_sel;

  assign ch_sel  = bus.addr[ADDR_W-1:3];
  assign reg_sel = bus.addr[2:0];
  assign ev      = tick_in & ~tick_q;

  // Write decode; channels beyond N_CH never match and are silently dropped.
  always_comb begin
    wr_ctrl   = '0;
    wr_load   = '0;
    wr_cmp    = '0;
    wr_status = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (bus.we && (ch_sel == CH_W'(i))) begin
        wr_ctrl[i]   = (reg_sel == 3'd0);
        wr_load[i]   = (reg_sel == 3'd1);
        wr_cmp[i]    = (reg_sel == 3'd2);
        wr_status[i] = (reg_sel == 3'd4);
      end
    end
  end

  // Per-channel next state; register writes take precedence over a same-cycle tick.
  always_comb begin
    en_d      = en_q;
    irq_en_d  = irq_en_q;
    expired_d = expired_q;
    mode_d    = mode_q;
    load_d    = load_q;
    cmp_d     = cmp_q;
    count_d   = count_q;
    cnt_out_d = '0;
    exp_set   = '0;
    for (int i = 0; i < N_CH; i++) begin
      case (mode_q[i])
        M_ONESHOT: cnt_out_d[i] = cnt_out[i];
        M_PWM:     cnt_out_d[i] = (count_q[i] < cmp_q[i]);
        default:   cnt_out_d[i] = 1'b0;
      endcase

      if (wr_ctrl[i]) begin
        en_d[i]      = bus.wdata[0];
        mode_d[i]    = mode_e'(bus.wdata[2:1]);
        irq_en_d[i]  = bus.wdata[3];
        cnt_out_d[i] = 1'b0;
      end else if (wr_load[i]) begin
        load_d[i]    = bus.wdata[WIDTH-1:0];
        count_d[i]   = bus.wdata[WIDTH-1:0];
        cnt_out_d[i] = 1'b0;
      end else if (ev[i] && en_q[i]) begin
        case (mode_q[i])
          M_ONESHOT: begin
            if (count_q[i] > WIDTH'(1)) begin
              count_d[i] = count_q[i] - WIDTH'(1);
            end else if (count_q[i] == WIDTH'(1)) begin
              count_d[i]   = '0;
              exp_set[i]   = 1'b1;
              cnt_out_d[i] = 1'b1;
              en_d[i]      = 1'b0;
            end
          end
          M_PERIODIC: begin
            if (count_q[i] > WIDTH'(1)) begin
              count_d[i] = count_q[i] - WIDTH'(1);
            end else if (count_q[i] == WIDTH'(1)) begin
              count_d[i]   = load_q[i];
              exp_set[i]   = 1'b1;
              cnt_out_d[i] = 1'b1;
            end
          end
          M_PWM: begin
            if ((WP1'(count_q[i]) + WP1'(1)) >= WP1'(load_q[i])) begin
              count_d[i] = '0;
              exp_set[i] = 1'b1;
            end else begin
              count_d[i] = count_q[i] + WIDTH'(1);
            end
          end
          M_FREE: begin
            count_d[i] = count_q[i] + WIDTH'(1);
            if (&count_q[i]) begin
              exp_set[i]   = 1'b1;
              cnt_out_d[i] = 1'b1;
            end
          end
          default: ;
        endcase
      end

      if (wr_cmp[i]) begin
        cmp_d[i] = bus.wdata[WIDTH-1:0];
      end

      // A same-cycle expiry beats a write-1 clear.
      if (exp_set[i]) begin
        expired_d[i] = 1'b1;
      end else if (wr_status[i] && bus.wdata[0]) begin
        expired_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      en_q      <= '0;
      irq_en_q  <= '0;
      expired_q <= '0;
      tick_q    <= '0;
      cnt_out   <= '0;
      irq       <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        mode_q[i]  <= M_ONESHOT;
        load_q[i]  <= '0;
        cmp_q[i]   <= '0;
        count_q[i] <= '0;
      end
    end else begin
      en_q      <= en_d;
      irq_en_q  <= irq_en_d;
      expired_q <= expired_d;
      tick_q    <= tick_in;
      cnt_out   <= cnt_out_d;
      irq       <= |(expired_q & irq_en_q);
      mode_q    <= mode_d;
      load_q    <= load_d;
      cmp_q     <= cmp_d;
      count_q   <= count_d;
    end
  end

  // Combinational read-back, zero-extended; unmapped registers and channels read 0.
  always_comb begin
    bus.rdata = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (ch_sel == CH_W'(i)) begin
        case (reg_sel)
          3'd0:    bus.rdata = 32'({irq_en_q[i], mode_q[i], en_q[i]});
          3'd1:    bus.rdata = 32'(load_q[i]);
          3'd2:    bus.rdata = 32'(cmp_q[i]);
          3'd3:    bus.rdata = 32'(count_q[i]);
          3'd4:    bus.rdata = 32'(expired_q[i]);
          default: bus.rdata = '0;
        endcase
      end
    end
  end

endmodule
